// File: rtl/axil_burst_reader.sv
// axil_burst_reader
//   Breaks a multi-beat read burst into single-beat AXI4-Lite AR/R
//   transactions. It issues one transaction per beat at incrementing word
//   addresses and forwards each returned word on a valid/ready stream. It
//   pulses o_done when the burst finishes or is aborted.
//
// Ports
//   clk, arstn              clock, asynchronous active-low reset
//   i_start/i_base_addr/i_len  burst request (i_len = beats - 1), IDLE only
//   o_busy, o_done, o_error status (o_error sticky until next accepted start)
//   o_araddr/o_arvalid/i_arready               AXI4-Lite read address channel
//   i_rdata/i_rresp/i_rvalid/o_rready          AXI4-Lite read data channel
//   o_data/o_data_valid/i_data_ready           output beat stream
module axil_burst_reader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEN_WIDTH-1:0]  i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_rresp,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  input  logic                  i_data_ready
);

  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_PUSH,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_araddr;
  logic [LEN_WIDTH-1:0]    r_len;
  logic [LEN_WIDTH-1:0]    r_count;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_error;
  logic                    w_last;
  logic                    w_resp_ok;

  // Compare before incrementing, so i_len = all-ones runs 2**LEN_WIDTH beats
  // and the counter never has to hold the beat total.
  assign w_last    = (r_count == r_len);
  assign w_resp_ok = (i_rresp == 2'b00);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (i_start)   w_next = S_ADDR;
      S_ADDR: if (i_arready) w_next = S_DATA;
      S_DATA: begin
        if (i_rvalid) w_next = w_resp_ok ? S_PUSH : S_DONE;
      end
      S_PUSH: begin
        if (i_data_ready) w_next = w_last ? S_DONE : S_ADDR;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // r_araddr always holds base + count*STRIDE. It advances together with
  // the count, which keeps it registered and stable throughout S_ADDR.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_araddr <= '0;
      r_len    <= '0;
      r_count  <= '0;
      r_data   <= '0;
      r_error  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_araddr <= i_base_addr;
            r_len    <= i_len;
            r_count  <= '0;
            r_error  <= 1'b0;
          end
        end
        S_DATA: begin
          if (i_rvalid) begin
            if (w_resp_ok) r_data  <= i_rdata;
            else           r_error <= 1'b1;
          end
        end
        S_PUSH: begin
          if (i_data_ready && !w_last) begin
            r_count  <= r_count + 1'b1;
            r_araddr <= r_araddr + STRIDE;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs decode the state register directly, so an async reset
  // drops them in the same instant.
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);
  assign o_arvalid    = (r_state == S_ADDR);
  assign o_rready     = (r_state == S_DATA);
  assign o_data_valid = (r_state == S_PUSH);
  assign o_araddr     = r_araddr;
  assign o_data       = r_data;
  assign o_error      = r_error;

endmodule
